// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared widths, control-bundle bit positions and skid state encoding for the ID/EX register
package id_ex_pkg;
  localparam int CTRL_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int AUX_W_DEF = 44;
  localparam int CTRL_WB_EN = 9;
  localparam int CTRL_MEM_READ = 8;
  localparam int CTRL_MEM_WRITE = 7;
  localparam int CTRL_B = 6;
  localparam int CTRL_S = 5;
  localparam int CTRL_IMM = 4;
  localparam int CTRL_ALU_LSB = 0;
  localparam int CTRL_ALU_W = 4;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one pipeline slot holding valid, control and payload; clear kills valid+ctrl only
module pipe_entry #(
  parameter int CTRL_W = 10,
  parameter int PAY_W = 140
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_ld,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [PAY_W-1:0]  i_pay,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [PAY_W-1:0]  o_pay
);
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [PAY_W-1:0]  r_pay;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl <= '0;
      r_pay <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_ctrl <= '0;
    end else if (i_ld) begin
      r_valid <= 1'b1;
      r_ctrl <= i_ctrl;
      r_pay <= i_pay;
    end
  end
  assign o_valid = r_valid;
  assign o_ctrl = r_ctrl;
  assign o_pay = r_pay;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX valid/ready pipeline register with flush and bubble counter.
// Define ID_EX_SKID_EN to add a skid entry and a registered in_ready.
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AUX_W = AUX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [AUX_W-1:0]  in_aux,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_val_rn,
  input  logic [DATA_W-1:0] in_val_rm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [AUX_W-1:0]  out_aux,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_val_rn,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [15:0]       bubble_cnt
);
  localparam int PAY_W = AUX_W + 3 * DATA_W;
  logic              w_in_fire, w_out_fire, w_ld_main, w_clr_main;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [PAY_W-1:0]  w_in_pay, w_main_pay, w_out_pay;
  logic [15:0]       r_bubble_cnt;
  assign w_in_pay = {in_aux, in_pc, in_val_rn, in_val_rm};
  assign {out_aux, out_pc, out_val_rn, out_val_rm} = w_out_pay;
  assign w_in_fire = in_valid & in_ready & ~flush;
  assign w_out_fire = out_valid & out_ready;
`ifdef ID_EX_SKID_EN
  skid_state_e       r_state, w_next;
  logic              r_in_ready, w_skid_valid, w_ld_skid, w_clr_skid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [PAY_W-1:0]  w_skid_pay;
  always_ff @(posedge clk) begin
    r_state <= rst ? ST_EMPTY : w_next;
    r_in_ready <= rst | (w_next != ST_TWO);
  end
  always_comb begin
    w_next = flush ? ST_EMPTY :
             (r_state == ST_EMPTY) ? (w_in_fire ? ST_ONE : ST_EMPTY) :
             (r_state == ST_ONE) ? ((w_in_fire & ~w_out_fire) ? ST_TWO :
                                    (w_out_fire & ~w_in_fire) ? ST_EMPTY : ST_ONE) :
             (w_out_fire ? ST_ONE : ST_TWO);
  end
  // In TWO the main slot refills from the skid slot, preserving order
  always_comb begin
    w_ld_skid = (r_state == ST_ONE) & w_in_fire & ~w_out_fire;
    w_clr_skid = flush | ((r_state == ST_TWO) & w_out_fire);
    w_ld_main = (r_state == ST_TWO) ? w_out_fire : (w_in_fire & ((r_state == ST_EMPTY) | w_out_fire));
  end
  assign in_ready = r_in_ready & ~rst;
  assign w_main_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;
  assign w_main_pay = w_skid_valid ? w_skid_pay : w_in_pay;
  pipe_entry #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_skid (
    .clk(clk), .rst(rst), .i_clr(w_clr_skid), .i_ld(w_ld_skid),
    .i_ctrl(in_ctrl), .i_pay(w_in_pay),
    .o_valid(w_skid_valid), .o_ctrl(w_skid_ctrl), .o_pay(w_skid_pay)
  );
`else
  assign in_ready = ~rst & (~out_valid | out_ready);
  assign w_ld_main = w_in_fire;
  assign w_main_ctrl = in_ctrl;
  assign w_main_pay = w_in_pay;
`endif
  assign w_clr_main = flush | (w_out_fire & ~w_ld_main);
  pipe_entry #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_main (
    .clk(clk), .rst(rst), .i_clr(w_clr_main), .i_ld(w_ld_main),
    .i_ctrl(w_main_ctrl), .i_pay(w_main_pay),
    .o_valid(out_valid), .o_ctrl(out_ctrl), .o_pay(w_out_pay)
  );
  always_ff @(posedge clk) begin
    r_bubble_cnt <= rst ? 16'd0 :
                    (~out_valid & (r_bubble_cnt != 16'hFFFF)) ? r_bubble_cnt + 16'd1 : r_bubble_cnt;
  end
  assign bubble_cnt = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed + random checks of id_ex_pipe_reg against a queue-based reference model
module tb_id_ex_pipe_reg;
  localparam int CW = 10;
  localparam int DW = 32;
  localparam int AW = 44;
`ifdef ID_EX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  typedef struct packed {
    logic [CW-1:0] c;
    logic [AW-1:0] a;
    logic [DW-1:0] pc;
    logic [DW-1:0] rn;
    logic [DW-1:0] rm;
  } ins_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl = '0, out_ctrl;
  logic [AW-1:0] in_aux = '0, out_aux;
  logic [DW-1:0] in_pc = '0, in_val_rn = '0, in_val_rm = '0;
  logic [DW-1:0] out_pc, out_val_rn, out_val_rm;
  logic [15:0]   bubble_cnt;

  ins_t        q[$];
  logic [15:0] m_cnt = '0;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_aux(in_aux), .in_pc(in_pc), .in_val_rn(in_val_rn), .in_val_rm(in_val_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_aux(out_aux),
    .out_pc(out_pc), .out_val_rn(out_val_rn), .out_val_rm(out_val_rm), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic [DW-1:0] pc);
    ins_t d;
    d.c = CW'($urandom);
    d.a = {12'($urandom), 32'($urandom)};
    d.pc = pc;
    d.rn = $urandom;
    d.rm = $urandom;
    return d;
  endfunction

  // One clock: drive, compare against model, then advance model at the edge
  task automatic cyc(input logic r, input logic f, input logic iv, input logic ordy, input ins_t d);
    logic ov, rdy;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    in_ctrl = d.c; in_aux = d.a; in_pc = d.pc; in_val_rn = d.rn; in_val_rm = d.rm;
    #1;
    ov = q.size() > 0;
    rdy = !r && (q.size() < CAP || (CAP == 1 && ordy));
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("out_valid", 64'(out_valid), 64'(ov));
    chk("out_ctrl", 64'(out_ctrl), ov ? 64'(q[0].c) : 64'd0);
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
    if (ov) begin
      chk("out_pc", 64'(out_pc), 64'(q[0].pc));
      chk("out_val_rn", 64'(out_val_rn), 64'(q[0].rn));
      chk("out_val_rm", 64'(out_val_rm), 64'(q[0].rm));
      chk("out_aux", 64'(out_aux), 64'(q[0].a));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cnt = '0;
    end else begin
      if (!ov && m_cnt != 16'hFFFF) m_cnt++;
      if (f) q.delete();
      else begin
        if (ov && ordy) void'(q.pop_front());
        if (iv && rdy) q.push_back(d);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    // reset with in_valid high
    cyc(1, 0, 1, 0, mk(32'h1));
    cyc(1, 0, 1, 1, mk(32'h2));
    @(negedge clk);
    #1;
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_rn", 64'(out_val_rn), 64'd0);
    chk("rst_rm", 64'(out_val_rm), 64'd0);
    chk("rst_aux", 64'(out_aux), 64'd0);
    // streaming
    cyc(0, 0, 1, 1, mk(32'h100));
    cyc(0, 0, 1, 1, mk(32'h104));
    cyc(0, 0, 1, 1, mk(32'h108));
    cyc(0, 0, 0, 1, mk(32'h0));
    cyc(0, 0, 0, 1, mk(32'h0));
    // stall, then release
    cyc(0, 0, 1, 1, mk(32'h200));
    cyc(0, 0, 1, 0, mk(32'h204));
    cyc(0, 0, 1, 0, mk(32'h208));
    cyc(0, 0, 1, 0, mk(32'h20C));
    cyc(0, 0, 0, 1, mk(32'h0));
    cyc(0, 0, 0, 1, mk(32'h0));
    cyc(0, 0, 0, 1, mk(32'h0));
    // flush beats simultaneous accept
    cyc(0, 0, 1, 1, mk(32'h300));
    cyc(0, 1, 1, 1, mk(32'h304));
    cyc(0, 0, 0, 1, mk(32'h0));
    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 60) == 0, ($urandom % 16) == 0, 1'($urandom), 1'($urandom), mk($urandom));
    // reset while full
    cyc(0, 0, 1, 0, mk(32'h400));
    cyc(0, 0, 1, 0, mk(32'h404));
    cyc(0, 0, 1, 0, mk(32'h408));
    cyc(1, 0, 1, 0, mk(32'h40C));
    cyc(0, 0, 0, 0, mk(32'h0));
    // bubble counter runs up to saturation and holds
    while (m_cnt != 16'hFFFF) cyc(0, 0, 0, 0, mk(32'h0));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, mk(32'h0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
